// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared types and helpers for the multi-channel PWM generator.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_CENTER = 2'd2
    } mode_t;

    localparam int c_arg_w = 32;

    // Counter value at the start of a period: DOWN starts at the period value.
    function automatic logic [c_arg_w-1:0] start_value(input logic [1:0] mode,
                                                       input logic [c_arg_w-1:0] per);
        return (mode == MODE_DOWN) ? per : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_prescaler
// Brief    : Divide-by-(presc+1) tick generator, cleared while the PWM is idle.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_prescaler #(
    parameter int P = 8
) (
    input  logic         clk50m,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [P-1:0] presc,
    output logic         tick
);

    logic [P-1:0] r_count;

    assign tick = !clr && (r_count == presc);

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Brief    : N-channel PWM with shared up/down/center counter and shadowed settings.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4,
    parameter int P = 8
) (
    input  logic                clk50m,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [P-1:0]        presc,
    input  logic [W-1:0]        per,
    input  logic [N-1:0][W-1:0] cmp,
    input  logic [N-1:0]        pol,
    output logic [W-1:0]        cnt,
    output logic [N-1:0]        pwm,
    output logic                evt
);

    logic                w_tick;
    logic [W-1:0]        r_cnt;
    logic                r_dir_up;
    logic [W-1:0]        r_per_a;
    logic [N-1:0][W-1:0] r_cmp_a;
    mode_t               r_mode_a;
    logic [N-1:0]        r_pwm;
    logic                r_evt;

    logic [W-1:0]        w_start;
    logic [W-1:0]        w_cnt_nxt;
    logic                w_dir_nxt;
    logic                w_evt_nxt;
    logic                w_boundary;
    logic [W-1:0]        w_per_nxt;
    logic [N-1:0][W-1:0] w_cmp_nxt;
    mode_t               w_mode_nxt;
    logic [N-1:0]        w_raw;

    pwm_prescaler #(.P(P)) u_presc (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .clr    (!en),
        .presc  (presc),
        .tick   (w_tick)
    );

    // Start value always comes from the incoming settings: it is only used
    // when those settings are being loaded into the active registers.
    assign w_start = W'(start_value(mode, c_arg_w'(per)));

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir_up;
        w_evt_nxt  = 1'b0;
        w_boundary = 1'b0;
        w_per_nxt  = r_per_a;
        w_cmp_nxt  = r_cmp_a;
        w_mode_nxt = r_mode_a;

        if (!en) begin
            w_cnt_nxt  = w_start;
            w_dir_nxt  = 1'b1;
            w_per_nxt  = per;
            w_cmp_nxt  = cmp;
            w_mode_nxt = mode_t'(mode);
        end else if (w_tick) begin
            case (r_mode_a)
                MODE_DOWN: begin
                    if (r_cnt == '0) w_boundary = 1'b1;
                    else             w_cnt_nxt  = r_cnt - 1'b1;
                end
                MODE_CENTER: begin
                    if (r_per_a == '0) begin
                        w_boundary = 1'b1;
                    end else if (r_dir_up && (r_cnt < r_per_a)) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else begin
                        // Turning at the top or descending; reaching 0 ends the period.
                        w_dir_nxt = 1'b0;
                        if (r_cnt <= 1) w_boundary = 1'b1;
                        else            w_cnt_nxt  = r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (r_cnt >= r_per_a) w_boundary = 1'b1;
                    else                  w_cnt_nxt  = r_cnt + 1'b1;
                end
            endcase

            if (w_boundary) begin
                w_evt_nxt  = 1'b1;
                w_cnt_nxt  = w_start;
                w_dir_nxt  = 1'b1;
                w_per_nxt  = per;
                w_cmp_nxt  = cmp;
                w_mode_nxt = mode_t'(mode);
            end
        end
    end

    // Compare against the values being loaded on this edge so pwm lines up with cnt.
    for (genvar i = 0; i < N; i++) begin : g_ch
        assign w_raw[i] = (w_cnt_nxt < w_cmp_nxt[i]);
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
            r_per_a  <= '0;
            r_cmp_a  <= '0;
            r_mode_a <= MODE_UP;
            r_pwm    <= '0;
            r_evt    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_dir_up <= w_dir_nxt;
            r_per_a  <= w_per_nxt;
            r_cmp_a  <= w_cmp_nxt;
            r_mode_a <= w_mode_nxt;
            r_pwm    <= en ? (w_raw ^ pol) : '0;
            r_evt    <= w_evt_nxt;
        end
    end

    assign cnt = r_cnt;
    assign pwm = r_pwm;
    assign evt = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Brief    : Self-checking bench for pwm_multi (W=5, N=2, P=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    localparam int W = 5;
    localparam int N = 2;
    localparam int P = 4;

    logic                clk50m = 1'b0;
    logic                rst_n  = 1'b0;
    logic                en     = 1'b0;
    logic [1:0]          mode   = 2'd0;
    logic [P-1:0]        presc  = '0;
    logic [W-1:0]        per    = '0;
    logic [N-1:0][W-1:0] cmp    = '0;
    logic [N-1:0]        pol    = '0;
    logic [W-1:0]        cnt;
    logic [N-1:0]        pwm;
    logic                evt;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi #(.W(W), .N(N), .P(P)) dut (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .presc  (presc),
        .per    (per),
        .cmp    (cmp),
        .pol    (pol),
        .cnt    (cnt),
        .pwm    (pwm),
        .evt    (evt)
    );

    always #10 clk50m = ~clk50m;

    typedef struct {
        logic [1:0]   mode;
        logic [P-1:0] presc;
        logic [W-1:0] per;
        logic [W-1:0] cmp0;
        logic [W-1:0] cmp1;
        logic [1:0]   pol;
        int           clocks;
        int           exp_hi0;
        int           exp_hi1;
        int           exp_evt;
        int           exp_cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cnt(input int target, input int max_clk, output int ok);
        ok = 0;
        for (int i = 0; i < max_clk; i++) begin
            @(negedge clk50m);
            if (int'(cnt) == target) begin
                ok = 1;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi0, hi1, nevt, ok, waited;

        //            mode  presc per cmp0 cmp1 pol  clk  hi0 hi1 evt cnt
        vecs[0] = '{2'd0, 4'd0, 5'd31, 5'd18, 5'd0, 2'b00, 64, 36,  0, 2, 0};
        vecs[1] = '{2'd1, 4'd0, 5'd9,  5'd3,  5'd10, 2'b00, 20, 6,  20, 2, 9};
        vecs[2] = '{2'd2, 4'd0, 5'd4,  5'd2,  5'd5, 2'b00, 16, 6,  16, 2, 0};
        vecs[3] = '{2'd0, 4'd3, 5'd7,  5'd8,  5'd4, 2'b01, 64, 0,  32, 2, 0};
        vecs[4] = '{2'd2, 4'd0, 5'd0,  5'd1,  5'd0, 2'b00, 8,  8,  0,  8, 0};
        vecs[5] = '{2'd3, 4'd0, 5'd3,  5'd2,  5'd3, 2'b10, 8,  4,  2,  2, 0};

        // Reset state
        repeat (2) @(negedge clk50m);
        check("reset_cnt", int'(cnt), 0);
        check("reset_pwm", int'(pwm), 0);
        check("reset_evt", int'(evt), 0);
        rst_n = 1'b1;
        @(negedge clk50m);

        // Table: settle with en=0, then run a whole number of periods
        for (int v = 0; v < 6; v++) begin
            en     = 1'b0;
            mode   = vecs[v].mode;
            presc  = vecs[v].presc;
            per    = vecs[v].per;
            cmp[0] = vecs[v].cmp0;
            cmp[1] = vecs[v].cmp1;
            pol    = vecs[v].pol;
            @(negedge clk50m);
            en = 1'b1;
            hi0 = 0; hi1 = 0; nevt = 0;
            for (int c = 0; c < vecs[v].clocks; c++) begin
                @(negedge clk50m);
                hi0  += int'(pwm[0]);
                hi1  += int'(pwm[1]);
                nevt += int'(evt);
            end
            check($sformatf("vec%0d_hi0", v), hi0, vecs[v].exp_hi0);
            check($sformatf("vec%0d_hi1", v), hi1, vecs[v].exp_hi1);
            check($sformatf("vec%0d_evt", v), nevt, vecs[v].exp_evt);
            check($sformatf("vec%0d_cnt", v), int'(cnt), vecs[v].exp_cnt);
        end

        // Shadow update: compare change at cnt=6 waits for the next event
        en = 1'b0; mode = 2'd0; presc = '0; per = 5'd15;
        cmp[0] = 5'd4; cmp[1] = 5'd0; pol = 2'b00;
        @(negedge clk50m);
        en = 1'b1;
        wait_cnt(6, 40, ok);
        check("shadow_wait6", ok, 1);
        cmp[0] = 5'd12;
        hi0 = 0; nevt = 0;
        repeat (9) begin
            @(negedge clk50m);
            hi0  += int'(pwm[0]);
            nevt += int'(evt);
        end
        check("shadow_old_hi", hi0, 0);
        check("shadow_no_evt", nevt, 0);
        @(negedge clk50m);
        check("shadow_evt", int'(evt), 1);
        check("shadow_evt_cnt", int'(cnt), 0);
        check("shadow_evt_pwm", int'(pwm[0]), 1);
        hi0 = 0;
        repeat (16) begin
            @(negedge clk50m);
            hi0 += int'(pwm[0]);
        end
        check("shadow_new_hi", hi0, 12);

        // Mode change mid-period waits for the event
        repeat (3) @(negedge clk50m);
        check("mode_pre_cnt", int'(cnt), 3);
        mode = 2'd1;
        @(negedge clk50m);
        check("mode_still_up", int'(cnt), 4);
        waited = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk50m);
            waited++;
            if (evt) begin
                ok = 1;
                break;
            end
        end
        check("mode_evt_seen", ok, 1);
        check("mode_evt_delay", waited, 12);
        check("mode_evt_cnt", int'(cnt), 15);
        @(negedge clk50m);
        check("mode_down_cnt", int'(cnt), 14);

        // Abort by dropping en at cnt=5
        en = 1'b0; mode = 2'd0; cmp[0] = 5'd12; pol = 2'b10;
        @(negedge clk50m);
        en = 1'b1;
        wait_cnt(5, 40, ok);
        check("abort_wait5", ok, 1);
        check("abort_pre_pwm", int'(pwm), 3);
        en = 1'b0;
        @(negedge clk50m);
        check("abort_en_cnt", int'(cnt), 0);
        check("abort_en_pwm", int'(pwm), 0);
        check("abort_en_evt", int'(evt), 0);

        // Asynchronous reset mid-period, then reload from the inputs
        en = 1'b1; pol = 2'b00;
        wait_cnt(9, 40, ok);
        check("rst_wait9", ok, 1);
        per = 5'd7;
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_cnt", int'(cnt), 0);
        check("rst_async_pwm", int'(pwm), 0);
        check("rst_async_evt", int'(evt), 0);
        @(negedge clk50m);
        rst_n = 1'b1;
        @(negedge clk50m);
        check("rst_first_evt", int'(evt), 1);
        check("rst_first_cnt", int'(cnt), 0);
        waited = 0; ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk50m);
            waited++;
            if (evt) begin
                ok = 1;
                break;
            end
        end
        check("rst_reload_seen", ok, 1);
        check("rst_reload_period", waited, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator: the parametrised successor of the single-channel counter/PWM block. One shared period counter drives N compare channels. Each channel has its own duty value and output polarity. The counter supports up, down and center-aligned modes and is paced by a prescaler. Period, compares and mode pass through shadow registers that update only at period boundaries, so outputs never glitch when software changes settings. It sits between the register interface and the pin muxes for motor and LED drive.

## Interface
- W, 8, counter/compare width in bits
- N, 4, number of PWM channels
- P, 8, prescaler width in bits
- clk50m  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable
- mode  in  2  counting mode (pwm_pkg::mode_t); takes effect at the next update event
- presc  in  P  prescaler divide-minus-one (0 = tick every clock)
- per  in  W  period value
- cmp  in  N×W (packed [N-1:0][W-1:0])  per-channel compare values
- pol  in  N  per-channel polarity; 1 inverts the output
- cnt  out  W  current counter value
- pwm  out  N  PWM outputs, registered
- evt  out  1  one-clock pulse on each update event (period boundary)

## Operation
- Reset (rst_n=0, asynchronous): cnt=0, pwm=0, evt=0, prescaler=0, dir=up; active regs per_a=0, cmp_a=0, mode_a=UP.
- Prescaler: tick when prescaler count == presc, then it clears; otherwise it increments. Only ticks advance cnt.
- en=0:
  - The prescaler clears and dir goes up.
  - cnt loads its start value: 0 for UP/CENTER, per for DOWN.
  - pwm is forced to 0 (no polarity applied) and evt=0.
  - Active regs copy per/cmp/mode every clock.
- MODE_UP:
  - Counts 0..per_a, then wraps to 0.
  - The wrap tick is the update event.
  - Period is per_a+1 ticks.
- MODE_DOWN:
  - Counts per_a..0, then reloads per_a.
  - The reload tick is the update event.
  - Period is per_a+1 ticks.
- MODE_CENTER:
  - Counts up 0..per_a, then down per_a-1..0, then up again.
  - The update event is the tick on which cnt becomes 0.
  - Period is 2·per_a ticks.
  - per_a=0: cnt stays 0 and every tick is an event.
- Mode 3 is reserved and behaves as MODE_UP.
- Update event: per_a, cmp_a and mode_a load from the inputs on the same edge that cnt takes its boundary value. The new cnt value is computed from the new settings: 0 for UP/CENTER, new per for DOWN.
- Channel output: raw_i = (cnt < cmp_a[i]); pwm[i] = raw_i XOR pol[i]. The result is registered and reflects the cnt and cmp_a values loaded on the same edge.
- Duty limits:
  - cmp_a=0: raw is permanently 0.
  - cmp_a>per_a: raw is permanently 1 in UP and DOWN modes, and in CENTER mode.
- Arithmetic: cnt is W-bit unsigned with no overflow. per=2^W−1 in UP mode wraps naturally.

## Timing
- The first tick comes 1+presc clocks after en rises. cnt changes on that edge.
- pwm and evt are registered and asserted on the same edge cnt takes the value that produces them.
- evt is high for exactly one clock, regardless of presc.
- Changes to per/cmp/mode while en=1 are invisible until the edge following the next update event.
- Asserting rst_n mid-period aborts immediately. Outputs go to reset values asynchronously.
- Releasing en mid-period: on the next edge the block enters the en=0 state. No partial period completes.

## Structure
- pwm_pkg holds:
  - typedef enum logic [1:0] mode_t {MODE_UP=0, MODE_DOWN=1, MODE_CENTER=2}.
  - Helper function start_value(mode, per).
- Sub-module pwm_prescaler (P, clk50m, rst_n, clr, presc → tick).
- Counter, direction flag, shadow regs and N compare channels (generate loop) stay in pwm_multi.

## Test plan
All scenarios use W=5, N=2, P=4.
- UP mode, presc=0, per=31, cmp={0:18, 1:0}, pol=0, en=1 after reset:
  - pwm[0] high 18 clocks, low 14 clocks.
  - pwm[1] always 0.
  - evt pulses every 32 clocks.
- DOWN mode, per=9, cmp[0]=3:
  - cnt runs 9..0.
  - pwm[0] high for cnt 2,1,0 (3 of 10 clocks).
  - evt on each reload to 9.
- CENTER mode, per=4, cmp[0]=2:
  - cnt sequence 0,1,2,3,4,3,2,1 repeats.
  - pwm[0] high 3 of 8 clocks, centered on cnt=0.
  - evt on each return to 0.
- Shadow update in UP mode, per=15, cmp[0]=4:
  - Write cmp[0]=12 at cnt=6; the current period still ends its high time at cnt=4.
  - High time becomes 12 only after the next evt.
  - Changing mode mid-period likewise waits for evt.
- Prescaler and polarity, presc=3, per=7, cmp[0]=8, pol[0]=1:
  - cnt advances every 4 clocks and evt period is 32 clocks.
  - cmp>per gives raw=1, so pwm[0] stays 0 with pol=1.
- Aborts:
  - Drop en at cnt=5: next edge gives cnt=0 and pwm=0.
  - Pulse rst_n low mid-period: outputs clear asynchronously, and after release settings reload from the inputs.
